// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller.
// Pending values are committed only at frame boundaries, with optional leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int unsigned DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        upd_ack
);

  logic [15:0] pcnt;
  logic [1:0]  idx;
  logic [15:0] disp;
  logic [15:0] pend;
  logic        pend_v;

  logic        tick;
  logic        commit;
  logic [3:0]  nib;
  logic        lz;
  logic [6:0]  dec;

  assign tick   = (pcnt == 16'(DIV - 1));
  assign commit = tick && (idx == 2'd3) && pend_v;

  always_comb begin
    nib = 4'd0;
    lz  = 1'b0;
    unique case (idx)
      2'd0: begin
        nib = disp[3:0];
        lz  = 1'b0;
      end
      2'd1: begin
        nib = disp[7:4];
        lz  = (disp[15:4] == 12'd0);
      end
      2'd2: begin
        nib = disp[11:8];
        lz  = (disp[15:8] == 8'd0);
      end
      2'd3: begin
        nib = disp[15:12];
        lz  = (disp[15:12] == 4'd0);
      end
    endcase
  end

  always_comb begin
    dec = 7'b0000001;
    unique case (nib)
      4'd0:    dec = 7'b1111110;
      4'd1:    dec = 7'b0110000;
      4'd2:    dec = 7'b1101101;
      4'd3:    dec = 7'b1111001;
      4'd4:    dec = 7'b0110011;
      4'd5:    dec = 7'b1011011;
      4'd6:    dec = 7'b1011111;
      4'd7:    dec = 7'b1110000;
      4'd8:    dec = 7'b1111111;
      4'd9:    dec = 7'b1111011;
      default: dec = 7'b0000001;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt    <= '0;
      idx     <= '0;
      disp    <= '0;
      pend    <= '0;
      pend_v  <= 1'b0;
      seg     <= '0;
      an      <= 4'b1111;
      upd_ack <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 16'd1;
      if (tick) idx <= idx + 2'd1;
      if (commit) disp <= pend;
      // A load on the commit tick replaces pend after the old one is taken.
      if (load) begin
        pend   <= value;
        pend_v <= 1'b1;
      end else if (commit) begin
        pend_v <= 1'b0;
      end
      upd_ack <= commit;
      an      <= ~(4'b0001 << idx);
      seg     <= (blank_lz && lz) ? 7'b0000000 : dec;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIV=4 (16-cycle frames).
// Expected per-cycle {an,seg,upd_ack} entries are queued per frame and popped each cycle.
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        upd_ack;

  int compared;
  int mismatched;
  string cur_tag;
  logic [11:0] sb [$];

  seg7_scan_ctrl #(.DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .upd_ack  (upd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      default: return 7'b0000001;
    endcase
  endfunction

  function automatic logic [11:0] exp_entry(
    input logic [15:0] v, input logic blz, input int d, input logic ack);
    logic [3:0] a;
    logic [6:0] s;
    logic [15:0] hi;
    a  = 4'b1111;
    a[d] = 1'b0;
    hi = v >> (4 * d);
    s  = seg_of(hi[3:0]);
    if (blz && d >= 1 && hi == 16'd0) s = 7'b0000000;
    return {a, s, ack};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed an/seg/ack=%b_%b_%b expected=%b_%b_%b", tag,
             obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  task automatic cyc(input int i);
    logic [11:0] e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s[%0d] scoreboard empty observed=%b", cur_tag, i,
             {an, seg, upd_ack});
    end else begin
      e = sb.pop_front();
      check($sformatf("%s[%0d]", cur_tag, i), {an, seg, upd_ack}, e);
    end
  endtask

  task automatic run_frame(
    input string tag, input logic [15:0] v, input logic blz,
    input logic ack, input int n,
    input int la, input logic [15:0] va,
    input int lb, input logic [15:0] vb);
    cur_tag = tag;
    for (int i = 0; i < n; i++)
      sb.push_back(exp_entry(v, blz, i / 4, ack && (i == 15)));
    for (int i = 0; i < n; i++) begin
      blank_lz = blz;
      load     = (i == la) || (i == lb);
      value    = (i == lb) ? vb : va;
      cyc(i);
    end
    load = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    load       = 1'b0;
    value      = 16'h0;
    blank_lz   = 1'b0;
    #12;
    check("reset_hold", {an, seg, upd_ack}, {4'b1111, 7'b0000000, 1'b0});
    #10 rst_n = 1'b1;

    run_frame("idle0", 16'h0000, 1'b0, 1'b0, 16, -1, 16'h0, -1, 16'h0);
    run_frame("idle1", 16'h0000, 1'b0, 1'b0, 16, -1, 16'h0, -1, 16'h0);
    run_frame("ld1234", 16'h0000, 1'b0, 1'b1, 16, 5, 16'h1234, -1, 16'h0);
    run_frame("sh1234", 16'h1234, 1'b0, 1'b1, 16, 3, 16'h0070, -1, 16'h0);
    run_frame("blz0070", 16'h0070, 1'b1, 1'b1, 16, 2, 16'h0000, -1, 16'h0);
    run_frame("blz0000", 16'h0000, 1'b1, 1'b1, 16, 4, 16'h9999, 15, 16'h5555);
    run_frame("sh9999", 16'h9999, 1'b0, 1'b1, 16, -1, 16'h0, -1, 16'h0);
    run_frame("sh5555", 16'h5555, 1'b0, 1'b1, 16, 7, 16'hA00F, -1, 16'h0);
    run_frame("shA00F", 16'hA00F, 1'b0, 1'b0, 16, -1, 16'h0, -1, 16'h0);
    run_frame("blzA00F", 16'hA00F, 1'b1, 1'b0, 16, -1, 16'h0, -1, 16'h0);
    run_frame("part", 16'hA00F, 1'b1, 1'b0, 7, 1, 16'h1111, -1, 16'h0);

    rst_n = 1'b0;
    #1;
    check("reset_async", {an, seg, upd_ack}, {4'b1111, 7'b0000000, 1'b0});
    @(posedge clk);
    @(posedge clk);
    #3;
    check("reset_held", {an, seg, upd_ack}, {4'b1111, 7'b0000000, 1'b0});
    rst_n = 1'b1;

    run_frame("post_rst0", 16'h0000, 1'b1, 1'b0, 16, -1, 16'h0, -1, 16'h0);
    run_frame("post_rst1", 16'h0000, 1'b0, 1'b0, 16, -1, 16'h0, -1, 16'h0);
    run_frame("post_rst2", 16'h0000, 1'b0, 1'b0, 16, -1, 16'h0, -1, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
